// File: rtl/c1541_pkg.sv
// Shared types and helpers for the c1541 SD block arbiter.
// Holds the arbiter state enum, the SD block size and the round-robin
// selection function used by c1541_rr_pick.
package c1541_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int SD_BLOCK_BYTES = 512;

  // Widest supported drive count; narrower request vectors are zero-padded.
  localparam int RR_MAX = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_result_t;

  // Scan last+1, last+2, ... (mod RR_MAX) and return the first requester.
  // Padding bits above NDRIVES are zero, so wrapping mod RR_MAX visits the
  // real units in the same order as wrapping mod NDRIVES would.
  function automatic rr_result_t rr_next(input logic [1:0]        last,
                                         input logic [RR_MAX-1:0] req);
    rr_result_t res;
    logic [1:0] cand;
    res = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      cand = last + 2'(k);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin priority picker for up to four track units.
// The unit after i_last has the highest priority; i_last itself the lowest.
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 2
) (
  input  logic [1:0]         i_last,
  input  logic [NDRIVES-1:0] i_req,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  logic [RR_MAX-1:0] w_req_pad;
  rr_result_t        w_res;

  // Pad the request vector to the fixed picker width and select.
  always_comb begin
    w_req_pad                = '0;
    w_req_pad[NDRIVES-1:0]   = i_req;
    w_res                    = rr_next(i_last, w_req_pad);
  end

  assign o_valid = w_res.valid;
  assign o_idx   = w_res.idx;

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block port between NDRIVES
// c1541 track units. One 512-byte block transfer is granted at a time;
// buffer write strobes and write data are routed to/from the granted unit.
//
// Handshake: each unit holds drv_rd/drv_wr as a level; it is sampled only
// in IDLE. The host answers sd_rd/sd_wr with sd_ack high for the whole
// block; the arbiter drops sd_rd/sd_wr on the first sd_ack cycle, mirrors
// sd_ack onto drv_ack[grant] one cycle late, and inserts one RELEASE cycle
// with all acks low after sd_ack falls.
//
// Optional feature macro: C1541_ARB_TIMEOUT_EN enables a REQ-state
// watchdog (TIMEOUT_CYCLES) that abandons a request the host never acks
// and sets the sticky timeout_err flag.
module c1541_sd_arbiter
  import c1541_pkg::*;
#(
  parameter int          NDRIVES        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*NDRIVES-1:0]  drv_lba,
  input  logic [NDRIVES-1:0]     drv_rd,
  input  logic [NDRIVES-1:0]     drv_wr,
  output logic [NDRIVES-1:0]     drv_ack,
  input  logic [8*NDRIVES-1:0]   drv_buff_din,
  output logic [NDRIVES-1:0]     drv_buff_wr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic                   timeout_err,
  output arb_state_t             dbg_state,
  output logic [1:0]             dbg_grant
);

  // Reject unsupported drive counts and a zero watchdog limit at elaboration.
  if (NDRIVES < 1 || NDRIVES > RR_MAX || TIMEOUT_CYCLES == 16'd0) begin : g_param_check
    $error("c1541_sd_arbiter: NDRIVES must be 1..4 and TIMEOUT_CYCLES nonzero");
  end

  localparam logic [1:0] LAST_INIT = 2'(NDRIVES - 1);

  arb_state_t         r_state;
  logic               r_sd_rd;
  logic               r_sd_wr;
  logic [31:0]        r_sd_lba;
  logic [NDRIVES-1:0] r_ack;
  logic [1:0]         r_grant;
  logic [1:0]         r_last;

  logic [NDRIVES-1:0]     w_req;
  logic [RR_MAX-1:0]      w_wr4;
  logic [RR_MAX-1:0][31:0] w_lba4;
  logic [RR_MAX-1:0][7:0] w_din4;
  logic [NDRIVES-1:0]     w_grant_oh;
  logic                   w_pick_valid;
  logic [1:0]             w_pick_idx;

  // Unpack per-unit buses into fixed-width arrays indexable by a 2-bit grant.
  always_comb begin
    w_req      = drv_rd | drv_wr;
    w_wr4      = '0;
    w_lba4     = '0;
    w_din4     = '0;
    w_grant_oh = '0;
    for (int i = 0; i < NDRIVES; i++) begin
      w_wr4[i]      = drv_wr[i];
      w_lba4[i]     = drv_lba[32*i +: 32];
      w_din4[i]     = drv_buff_din[8*i +: 8];
      w_grant_oh[i] = (r_grant == 2'(i));
    end
  end

  c1541_rr_pick #(
    .NDRIVES (NDRIVES)
  ) u_pick (
    .i_last  (r_last),
    .i_req   (w_req),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

`ifdef C1541_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_timeout_err;
`endif

  // Arbitration FSM: grant, host request, transfer tracking, release gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sd_rd  <= 1'b0;
      r_sd_wr  <= 1'b0;
      r_sd_lba <= '0;
      r_ack    <= '0;
      r_grant  <= '0;
      r_last   <= LAST_INIT;
`ifdef C1541_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_pick_valid) begin
            r_grant  <= w_pick_idx;
            r_sd_lba <= w_lba4[w_pick_idx];
            // Write wins when a unit raises rd and wr together.
            r_sd_wr  <= w_wr4[w_pick_idx];
            r_sd_rd  <= ~w_wr4[w_pick_idx];
            r_state  <= REQ;
`ifdef C1541_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (sd_ack) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_ack   <= w_grant_oh;
            r_state <= XFER;
          end
`ifdef C1541_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
            // Abandon the request: one ack pulse via XFER (sd_ack is low,
            // so XFER exits to RELEASE on the next cycle).
            r_sd_rd       <= 1'b0;
            r_sd_wr       <= 1'b0;
            r_ack         <= w_grant_oh;
            r_timeout_err <= 1'b1;
            r_state       <= XFER;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        XFER: begin
          if (!sd_ack) begin
            r_ack   <= '0;
            r_last  <= r_grant;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate the host buffer strobe to the granted unit during the transfer.
  always_comb begin
    drv_buff_wr = '0;
    for (int i = 0; i < NDRIVES; i++) begin
      drv_buff_wr[i] = sd_buff_wr & (r_state == XFER) & w_grant_oh[i];
    end
  end

  assign sd_buff_din = w_din4[r_grant];
  assign drv_ack     = r_ack;
  assign sd_lba      = r_sd_lba;
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign dbg_state   = r_state;
  assign dbg_grant   = r_grant;

`ifdef C1541_ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Bench for c1541_sd_arbiter with two track units.
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
// Build with C1541_ARB_TIMEOUT_EN defined to also cover the watchdog.
module tb_c1541_sd_arbiter;
  import c1541_pkg::*;

  localparam logic [31:0] LBA0 = 32'h0000_0150;
  localparam logic [31:0] LBA1 = 32'h0000_02A0;
  localparam logic [7:0]  DIN0 = 8'h3C;
  localparam logic [7:0]  DIN1 = 8'hA5;

  logic        clk;
  logic        reset;
  logic [63:0] drv_lba;
  logic [1:0]  drv_rd;
  logic [1:0]  drv_wr;
  logic [1:0]  drv_ack;
  logic [15:0] drv_buff_din;
  logic [1:0]  drv_buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        timeout_err;
  arb_state_t  dbg_state;
  logic [1:0]  dbg_grant;

  int total;
  int bad;

  logic [1:0] exp_q[$];

  c1541_sd_arbiter #(
    .NDRIVES        (2),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state),
    .dbg_grant    (dbg_grant)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [1:0] rd;
    logic [1:0] wr;
    logic       ack;
    logic       bwr;
    arb_state_t st;
    logic       srd;
    logic       swr;
    logic [31:0] lba;
    logic [1:0] dack;
    logic [1:0] dbw;
    logic [7:0] din;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  function automatic vec_t v(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                             input logic ack, input logic bwr, input arb_state_t st,
                             input logic srd, input logic swr, input logic [31:0] lba,
                             input logic [1:0] dack, input logic [1:0] dbw, input logic [7:0] din);
    vec_t r;
    r.rst = rst; r.rd = rd; r.wr = wr; r.ack = ack; r.bwr = bwr;
    r.st = st; r.srd = srd; r.swr = swr; r.lba = lba;
    r.dack = dack; r.dbw = dbw; r.din = din;
    return r;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int hi;
    int cnt;
    int bad_follow;
    int bad_other;
    int bw0;
    int bw1;
    int bad_din;
    logic [1:0] e;

    total = 0;
    bad = 0;
    reset = 1'b1;
    drv_rd = '0;
    drv_wr = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    drv_lba = {LBA1, LBA0};
    drv_buff_din = {DIN1, DIN0};

    //          rst   rd     wr     ack   bwr   state    srd   swr   lba   dack   dbw    din
    tbl[0]  = v(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, IDLE,    1'b0, 1'b0, 32'h0, 2'b00, 2'b00, DIN0);
    tbl[1]  = v(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, REQ,     1'b0, 1'b1, LBA1, 2'b00, 2'b00, DIN1);
    tbl[2]  = v(1'b0, 2'b00, 2'b10, 1'b1, 1'b0, XFER,    1'b0, 1'b0, LBA1, 2'b10, 2'b00, DIN1);
    tbl[3]  = v(1'b0, 2'b00, 2'b10, 1'b1, 1'b1, XFER,    1'b0, 1'b0, LBA1, 2'b10, 2'b10, DIN1);
    tbl[4]  = v(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, XFER,    1'b0, 1'b0, LBA1, 2'b10, 2'b10, DIN1);
    tbl[5]  = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, RELEASE, 1'b0, 1'b0, LBA1, 2'b00, 2'b00, DIN1);
    tbl[6]  = v(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, IDLE,    1'b0, 1'b0, LBA1, 2'b00, 2'b00, DIN1);
    tbl[7]  = v(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, REQ,     1'b1, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[8]  = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, REQ,     1'b1, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[9]  = v(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, XFER,    1'b0, 1'b0, LBA0, 2'b01, 2'b00, DIN0);
    tbl[10] = v(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, XFER,    1'b0, 1'b0, LBA0, 2'b01, 2'b01, DIN0);
    tbl[11] = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, RELEASE, 1'b0, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[12] = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, IDLE,    1'b0, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[13] = v(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, REQ,     1'b0, 1'b1, LBA0, 2'b00, 2'b00, DIN0);
    tbl[14] = v(1'b0, 2'b01, 2'b01, 1'b1, 1'b0, XFER,    1'b0, 1'b0, LBA0, 2'b01, 2'b00, DIN0);
    tbl[15] = v(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, IDLE,    1'b0, 1'b0, 32'h0, 2'b00, 2'b00, DIN0);
    tbl[16] = v(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, REQ,     1'b1, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[17] = v(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, XFER,    1'b0, 1'b0, LBA0, 2'b01, 2'b00, DIN0);
    tbl[18] = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, RELEASE, 1'b0, 1'b0, LBA0, 2'b00, 2'b00, DIN0);
    tbl[19] = v(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, IDLE,    1'b0, 1'b0, LBA0, 2'b00, 2'b00, DIN0);

    for (int i = 0; i < NV; i++) begin
      reset      = tbl[i].rst;
      drv_rd     = tbl[i].rd;
      drv_wr     = tbl[i].wr;
      sd_ack     = tbl[i].ack;
      sd_buff_wr = tbl[i].bwr;
      tick();
      chk($sformatf("v%0d state", i), 32'(dbg_state), 32'(tbl[i].st));
      chk($sformatf("v%0d sd_rd", i), 32'(sd_rd), 32'(tbl[i].srd));
      chk($sformatf("v%0d sd_wr", i), 32'(sd_wr), 32'(tbl[i].swr));
      chk($sformatf("v%0d sd_lba", i), sd_lba, tbl[i].lba);
      chk($sformatf("v%0d drv_ack", i), 32'(drv_ack), 32'(tbl[i].dack));
      chk($sformatf("v%0d drv_buff_wr", i), 32'(drv_buff_wr), 32'(tbl[i].dbw));
      chk($sformatf("v%0d sd_buff_din", i), 32'(sd_buff_din), 32'(tbl[i].din));
      chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'd0);
    end
    reset = 1'b0;
    drv_rd = '0;
    drv_wr = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;

    // Single read with a long host ack: drv_ack[0] tracks sd_ack one cycle late.
    bad_follow = 0;
    bad_other = 0;
    drv_rd = 2'b01;
    tick();
    chk("seq1 sd_rd", 32'(sd_rd), 32'd1);
    chk("seq1 sd_lba", sd_lba, LBA0);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (drv_ack[0] !== sd_ack) bad_follow++;
      if (drv_ack[1] !== 1'b0) bad_other++;
    end
    sd_ack = 1'b1;
    drv_rd = 2'b00;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (drv_ack[0] !== sd_ack) bad_follow++;
      if (drv_ack[1] !== 1'b0) bad_other++;
    end
    sd_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (drv_ack[0] !== sd_ack) bad_follow++;
      if (drv_ack[1] !== 1'b0) bad_other++;
    end
    chk("seq1 ack0 follows", 32'(bad_follow), 32'd0);
    chk("seq1 ack1 quiet", 32'(bad_other), 32'd0);
    chk("seq1 back to idle", 32'(dbg_state), 32'(IDLE));

    // Contention after reset: grants alternate 0,1,0,1 with a 3-cycle gap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("seq2 reset state", 32'(dbg_state), 32'(IDLE));
    exp_q = {2'd0, 2'd1, 2'd0, 2'd1};
    drv_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!sd_rd && cnt < 20);
      chk($sformatf("seq2 req%0d seen", k), 32'(sd_rd), 32'd1);
      if (k > 0) chk($sformatf("seq2 gap%0d", k), 32'(cnt), 32'd3);
      sd_ack = 1'b1;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("seq2 grant%0d", k), 32'(drv_ack), (e == 2'd0) ? 32'd1 : 32'd2);
      tick();
      tick();
      sd_ack = 1'b0;
    end
    drv_rd = 2'b00;
    tick();
    tick();
    chk("seq2 idle", 32'(dbg_state), 32'(IDLE));

    // Write routing from unit 1 across a full block of buffer strobes.
    drv_wr = 2'b10;
    tick();
    chk("seq3 sd_wr", 32'(sd_wr), 32'd1);
    chk("seq3 sd_rd", 32'(sd_rd), 32'd0);
    chk("seq3 din", 32'(sd_buff_din), 32'(DIN1));
    sd_ack = 1'b1;
    drv_wr = 2'b00;
    tick();
    chk("seq3 drv_ack", 32'(drv_ack), 32'd2);
    bw0 = 0;
    bw1 = 0;
    bad_din = 0;
    sd_buff_wr = 1'b1;
    for (int c = 0; c < SD_BLOCK_BYTES; c++) begin
      tick();
      if (drv_buff_wr[0]) bw0++;
      if (drv_buff_wr[1]) bw1++;
      if (sd_buff_din !== DIN1) bad_din++;
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    tick();
    chk("seq3 unit0 strobes", 32'(bw0), 32'd0);
    chk("seq3 unit1 strobes", 32'(bw1), 32'(SD_BLOCK_BYTES));
    chk("seq3 din stable", 32'(bad_din), 32'd0);

`ifdef C1541_ARB_TIMEOUT_EN
    // Host never acks: request dropped after 100 REQ cycles, sticky error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv_rd = 2'b01;
    hi = 0;
    tick();
    while (sd_rd && hi < 300) begin
      hi++;
      tick();
    end
    drv_rd = 2'b00;
    chk("tmo rd cycles", 32'(hi), 32'd100);
    chk("tmo ack pulse", 32'(drv_ack), 32'd1);
    chk("tmo err set", 32'(timeout_err), 32'd1);
    tick();
    chk("tmo ack low", 32'(drv_ack), 32'd0);
    chk("tmo release", 32'(dbg_state), 32'(RELEASE));
    tick();
    drv_rd = 2'b10;
    tick();
    chk("tmo next sd_rd", 32'(sd_rd), 32'd1);
    chk("tmo next lba", sd_lba, LBA1);
    sd_ack = 1'b1;
    drv_rd = 2'b00;
    tick();
    chk("tmo next ack", 32'(drv_ack), 32'd2);
    sd_ack = 1'b0;
    tick();
    chk("tmo err sticky", 32'(timeout_err), 32'd1);
`else
    hi = 0;
    chk("no-tmo err tied", 32'(timeout_err), 32'(hi));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c1541_sd_arbiter.md
# c1541_sd_arbiter

Shares the single host SD block interface (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/buffer bus) between `NDRIVES` track units (c1541 drives 8, 9, …). Each track unit sees a private, fully protocol-compatible SD port. The arbiter grants one 512-byte block transfer at a time in round-robin order, routes buffer traffic to the granted unit only, and returns per-unit acknowledges. It sits between the drive instances and the HPS/SD bridge, in the `clk` domain, where `sd_clk` is tied to `clk`.

## Interface
Parameters:
- `NDRIVES`, 2: number of requesting track units, 1..4.
- `TIMEOUT_CYCLES`, 16'd50000: `clk` cycles to wait for `sd_ack` rise. Used only with `C1541_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock. The block has one clock; `sd_clk` ports of all units connect to `clk`.
- `reset` in 1: synchronous, active-high.
- `drv_lba` in 32×NDRIVES: per-unit LBA.
- `drv_rd` in NDRIVES: per-unit read request (level).
- `drv_wr` in NDRIVES: per-unit write request (level).
- `drv_ack` out NDRIVES: per-unit acknowledge.
- `drv_buff_din` in 8×NDRIVES: per-unit write data, unit→SD.
- `drv_buff_wr` out NDRIVES: per-unit gated `sd_buff_wr`.
- `sd_lba` out 32: shared LBA.
- `sd_rd` out 1: shared read request.
- `sd_wr` out 1: shared write request.
- `sd_ack` in 1: host acknowledge.
- `sd_buff_wr` in 1: host buffer write strobe.
- `sd_buff_din` out 8: data muxed from the granted unit.
- `timeout_err` out 1: sticky timeout flag. Constant 0 without the macro.
- `sd_buff_addr`/`sd_buff_dout` fan out by wire to all units and do not pass through this block.

## Operation
- FSM states:
  - IDLE: scan units round-robin, starting at `last_grant+1` mod NDRIVES. The first unit with `drv_rd|drv_wr` wins. Latch `grant`, `drv_lba[grant]` and direction (write when `drv_wr` is set, including when `rd` and `wr` are both set), then go to REQ.
  - REQ: drive `sd_rd` or `sd_wr` = 1 and `sd_lba` = latched LBA. On `sd_ack`=1: deassert `sd_rd`/`sd_wr` and go to XFER.
  - XFER: `drv_ack[grant]` = 1. Stay while `sd_ack`=1. On `sd_ack`=0: set `last_grant`←`grant` and go to RELEASE.
  - RELEASE: one cycle with `drv_ack` all 0, then IDLE. This guarantees each unit sees a clean falling ack edge and can drop or re-raise its request.
- `drv_ack[i]` = 0 for every i ≠ `grant`, always.
- `drv_buff_wr[i]` = `sd_buff_wr` & (state==XFER) & (`grant`==i), combinational.
- `sd_buff_din` = `drv_buff_din[grant]`, combinational.
- A request deasserted by a unit while in REQ does not abort the transfer. The latched request completes.
- A unit's request is sampled only in IDLE. A new request from the last-granted unit is serviced only after every other pending unit has been served once.
- NDRIVES=1: grant is fixed at 0 and the FSM is otherwise identical.

## Timing
- Reset values: state IDLE, `sd_rd`=`sd_wr`=0, `sd_lba`=0, `drv_ack`=0, `grant`=0, `last_grant`=NDRIVES-1 (unit 0 wins first), `timeout_err`=0.
- A request sampled in IDLE at cycle t gives `sd_rd`/`sd_wr`/`sd_lba` registered valid at t+1.
- `sd_ack` rise at cycle a:
  - `sd_rd`/`sd_wr` = 0 at a+1.
  - `drv_ack[grant]` = 1 from a+1.
- `sd_ack` fall at cycle f:
  - `drv_ack` = 0 at f+1.
  - RELEASE at f+1.
  - IDLE at f+2.
  - Earliest next `sd_rd`/`sd_wr` at f+3.
- `reset` has priority in every state. If asserted mid-XFER, all outputs are 0 on the next cycle. The host transfer in flight is not tracked after reset.

## Configuration
- `C1541_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering REQ and increments each REQ cycle.
  - At `TIMEOUT_CYCLES` without `sd_ack`: drop `sd_rd`/`sd_wr`, set `timeout_err`, pulse `drv_ack[grant]`=1 for one cycle, then go to RELEASE.
  - `timeout_err` clears only on `reset`.
- Not defined: no counter. REQ waits indefinitely and `timeout_err` is tied to 0.

## Structure
- Package `c1541_pkg`:
  - `arb_state_t` enum: IDLE, REQ, XFER, RELEASE.
  - Constant `SD_BLOCK_BYTES`=512.
  - Function `rr_next(last, req)` returning the winning index and a valid bit.
- Sub-module `c1541_rr_pick`: combinational round-robin priority picker, parameterised by NDRIVES.

## Test plan
- Single request, read: `drv_rd[0]`=1, LBA 32'h0000_0150; host acks 3 cycles later for 600 cycles.
  - Required: `sd_rd`=1 and `sd_lba`=32'h150 one cycle after the request.
  - Required: `drv_ack[0]` follows `sd_ack` delayed 1 cycle, and `drv_ack[1]`=0 throughout.
- Contention: `drv_rd[0]` and `drv_rd[1]` assert on the same cycle, and both re-request immediately after each ack falls.
  - Required: grants are 0,1,0,1.
  - Required: the next `sd_rd` comes exactly 3 cycles after each `sd_ack` fall.
- Write routing: unit 1 issues `drv_wr` and drives `drv_buff_din[1]`=8'hA5 while unit 0 drives 8'h3C.
  - Required: `sd_buff_din`=8'hA5 and `sd_wr`=1.
  - Required: `drv_buff_wr[0]` is never 1 during 512 `sd_buff_wr` strobes.
- Read and write both set: `drv_rd[0]`=`drv_wr[0]`=1.
  - Required: `sd_wr`=1 and `sd_rd`=0.
- Reset mid-XFER: assert `reset` for 1 cycle while `sd_ack`=1.
  - Required: next cycle all outputs are 0, state is IDLE, and the next grant goes to unit 0.
- Timeout (macro defined, `TIMEOUT_CYCLES`=100): request with the host never acking.
  - Required: `sd_rd` drops after 100 REQ cycles.
  - Required: one-cycle `drv_ack` pulse, then `timeout_err`=1 sticky.
  - Required: the next request is serviced normally.
